// File: rtl/rs_age_issue_sel.sv
// Age-matrix RS issue selector: up to NUM_FU oldest ready entries per cycle, mapped round-robin onto FUs.
// Zero latency (grants are combinational); backpressure comes from fu_stall and per-FU FU_LAT busy counters.
module rs_age_issue_sel #(
    parameter int DEPTH  = 16,
    parameter int NUM_FU = 2,
    parameter int FU_LAT = 1
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset,
    input  logic                                     i_squash,
    input  logic [DEPTH-1:0]                         i_alloc,
    input  logic [DEPTH-1:0]                         i_inst_req,
    input  logic [NUM_FU-1:0]                        i_fu_stall,
    output logic [DEPTH-1:0]                         o_all_issued_insts,
    output logic [NUM_FU-1:0]                        o_fu_issued_insts,
    output logic [NUM_FU-1:0][$clog2(DEPTH)-1:0]     o_issue_idx,
    output logic [$clog2(NUM_FU+1)-1:0]              o_num_issued,
    output logic [NUM_FU-1:0]                        o_fu_avail
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int CNTW = $clog2(NUM_FU + 1);
    localparam int RRW  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int BCW  = $clog2(FU_LAT + 1);
    localparam int RKW  = $clog2(DEPTH + 1);

    logic [DEPTH-1:0]              r_valid;
    logic [DEPTH-1:0][DEPTH-1:0]   r_age;
    logic [NUM_FU-1:0][BCW-1:0]    r_busy;
    logic [RRW-1:0]                r_rr_ptr;

    logic [DEPTH-1:0]              w_eligible;
    logic [DEPTH-1:0]              w_issue;
    logic [DEPTH-1:0]              w_eff_alloc;
    logic [DEPTH-1:0]              w_surv;
    logic [DEPTH-1:0]              w_valid_n;
    logic [DEPTH-1:0][RKW-1:0]     w_rank;
    logic [DEPTH-1:0][DEPTH-1:0]   w_age_n;
    logic [NUM_FU-1:0]             w_avail;
    logic [CNTW-1:0]               w_avail_cnt;
    logic [CNTW-1:0]               w_num;
    logic [NUM_FU-1:0][RRW-1:0]    w_slot;
    logic [NUM_FU-1:0]             w_grant;
    logic [NUM_FU-1:0][IDXW-1:0]   w_idx;
    logic [RRW-1:0]                w_rr_n;
    logic [NUM_FU-1:0][BCW-1:0]    w_busy_n;

    always_comb begin
        w_avail     = '0;
        w_avail_cnt = '0;
        for (int f = 0; f < NUM_FU; f++) begin
            w_avail[f]  = !i_fu_stall[f] && (r_busy[f] == '0);
            w_avail_cnt = w_avail_cnt + CNTW'(w_avail[f]);
        end
    end

    // slot k = k-th available FU scanning upward from rr_ptr
    always_comb begin
        int k;
        int f;
        w_slot = '0;
        k      = 0;
        f      = 0;
        for (int o = 0; o < NUM_FU; o++) begin
            f = (int'(r_rr_ptr) + o) % NUM_FU;
            if (w_avail[f] && (k < NUM_FU)) begin
                w_slot[k] = RRW'(f);
                k         = k + 1;
            end
        end
    end

    always_comb begin
        w_eligible = i_inst_req & r_valid;
        w_issue    = '0;
        w_rank     = '0;
        w_num      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (w_eligible[j] && r_age[j][i])
                    w_rank[i] = w_rank[i] + RKW'(1);
            end
            if (w_eligible[i] && (int'(w_rank[i]) < int'(w_avail_cnt))) begin
                w_issue[i] = 1'b1;
                w_num      = w_num + CNTW'(1);
            end
        end
    end

    always_comb begin
        int s;
        s       = 0;
        w_grant = '0;
        w_idx   = '0;
        w_rr_n  = r_rr_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_issue[i]) begin
                s          = int'(w_slot[int'(w_rank[i])]);
                w_grant[s] = 1'b1;
                w_idx[s]   = IDXW'(i);
            end
        end
        if (w_num != '0)
            w_rr_n = RRW'((int'(w_slot[int'(w_num) - 1]) + 1) % NUM_FU);
    end

    // Allocating an already-valid entry is illegal; masking it keeps that entry untouched.
    always_comb begin
        w_eff_alloc = i_alloc & ~r_valid;
        w_surv      = r_valid & ~w_issue;
        w_valid_n   = w_surv | w_eff_alloc;
        w_age_n     = r_age;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_eff_alloc[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    w_age_n[i][j] = w_eff_alloc[j] && (j > i);
                    w_age_n[j][i] = w_surv[j] || (w_eff_alloc[j] && (j < i));
                end
            end
        end
        for (int f = 0; f < NUM_FU; f++) begin
            if (w_grant[f] && !i_squash)
                w_busy_n[f] = BCW'(FU_LAT - 1);
            else if (r_busy[f] != '0)
                w_busy_n[f] = r_busy[f] - BCW'(1);
            else
                w_busy_n[f] = r_busy[f];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_valid  <= '0;
            r_age    <= '0;
            r_busy   <= '0;
            r_rr_ptr <= '0;
        end else if (i_squash) begin
            r_valid <= '0;
            r_age   <= '0;
            r_busy  <= w_busy_n;
        end else begin
            r_valid <= w_valid_n;
            r_age   <= w_age_n;
            r_busy  <= w_busy_n;
            if (w_num != '0)
                r_rr_ptr <= w_rr_n;
        end
    end

    assign o_fu_avail         = w_avail;
    assign o_all_issued_insts = w_issue;
    assign o_fu_issued_insts  = w_grant;
    assign o_issue_idx        = w_idx;
    assign o_num_issued       = w_num;

endmodule
